// File: rtl/muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_StartE;
    logic [1:0]       i_OpE;
    logic [WIDTH-1:0] i_SrcAE;
    logic [WIDTH-1:0] i_SrcBE;
    logic             i_MfhiE;
    logic             i_MfloE;
    logic             i_MthiE;
    logic             i_MtloE;
    logic             i_FlushE;
    logic [WIDTH-1:0] o_HiLoE;
    logic             o_BusyE;
    logic             o_StallReqE;

    // Pipeline side: issues requests, observes results and stall.
    modport master (
        output i_StartE, i_OpE, i_SrcAE, i_SrcBE,
        output i_MfhiE, i_MfloE, i_MthiE, i_MtloE, i_FlushE,
        input  o_HiLoE, o_BusyE, o_StallReqE
    );

    // Unit side: consumes requests, produces results and stall.
    modport slave (
        input  i_StartE, i_OpE, i_SrcAE, i_SrcBE,
        input  i_MfhiE, i_MfloE, i_MthiE, i_MtloE, i_FlushE,
        output o_HiLoE, o_BusyE, o_StallReqE
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO register pair.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_unit_if.slave bus
);
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_q, neg_d;
    logic             rsign_q, rsign_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             signed_op;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum, rem_sh, diff;
    logic             any_req;

    // Operand magnitudes for the start cycle; MULTU/DIVU use raw values.
    assign signed_op = ~bus.i_OpE[0];
    assign a_mag = (signed_op && bus.i_SrcAE[WIDTH-1]) ? -bus.i_SrcAE : bus.i_SrcAE;
    assign b_mag = (signed_op && bus.i_SrcBE[WIDTH-1]) ? -bus.i_SrcBE : bus.i_SrcBE;

    // Stall is combinational so the hazard unit sees it in the same cycle.
    assign any_req         = bus.i_StartE | bus.i_MfhiE | bus.i_MfloE | bus.i_MthiE | bus.i_MtloE;
    assign bus.o_BusyE     = (state_q != S_IDLE);
    assign bus.o_StallReqE = bus.o_BusyE & any_req & ~bus.i_FlushE;
    assign bus.o_HiLoE     = bus.i_MfhiE ? hi_q : lo_q;

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
            a_raw_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            rsign_q <= rsign_d;
            dz_q    <= dz_d;
            a_raw_q <= a_raw_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state: accept in IDLE, one shift-add/shift-subtract step per RUN cycle, sign fix-up in FIX.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        b_d     = b_q;
        neg_d   = neg_q;
        rsign_d = rsign_q;
        dz_d    = dz_q;
        a_raw_d = a_raw_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sum     = '0;
        rem_sh  = '0;
        diff    = '0;

        case (state_q)
            S_IDLE: begin
                if (!bus.i_FlushE) begin
                    if (bus.i_StartE) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        op_d    = bus.i_OpE;
                        acc_d   = {WIDTH'(0), a_mag};
                        b_d     = b_mag;
                        neg_d   = signed_op & (bus.i_SrcAE[WIDTH-1] ^ bus.i_SrcBE[WIDTH-1]);
                        rsign_d = signed_op & bus.i_SrcAE[WIDTH-1];
                        dz_d    = (bus.i_SrcBE == '0);
                        a_raw_d = bus.i_SrcAE;
                    end else begin
                        if (bus.i_MthiE) hi_d = bus.i_SrcAE;
                        if (bus.i_MtloE) lo_d = bus.i_SrcAE;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
                if (!op_q[1]) begin
                    // Multiply: conditionally add multiplicand into the upper half, then shift right.
                    sum = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, b_q};
                    if (acc_q[0]) acc_d = {sum, acc_q[WIDTH-1:1]};
                    else          acc_d = {1'b0, acc_q[W2-1:1]};
                end else begin
                    // Divide: shift remainder/quotient left, keep the subtraction if it did not borrow.
                    rem_sh = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
                    diff   = rem_sh - {1'b0, b_q};
                    if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else              acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!op_q[1]) begin
                    {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                end else if (dz_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    lo_d = neg_q   ? -acc_q[WIDTH-1:0]  : acc_q[WIDTH-1:0];
                    hi_d = rsign_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a cycle-count/arithmetic reference model.
module tb_muldiv_unit;
    localparam int unsigned WIDTH = 32;
    localparam int LAT = 33;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   check_en;

    muldiv_unit_if #(.WIDTH(WIDTH)) bus ();
    muldiv_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: architectural HI/LO plus cycles remaining until the pending result lands.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        res = '0;
        case (op)
            2'b00: res = 64'(sa * sb);
            2'b01: res = ua * ub;
            2'b10: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else res = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
        return res;
    endfunction

    // Model update: a start makes the unit busy for LAT cycles, then HI/LO take the result.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
            p_hi   <= '0;
            p_lo   <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (!bus.i_FlushE) begin
            if (bus.i_StartE) begin
                {p_hi, p_lo} <= model_result(bus.i_OpE, bus.i_SrcAE, bus.i_SrcBE);
                m_left <= LAT;
            end else begin
                if (bus.i_MthiE) m_hi <= bus.i_SrcAE;
                if (bus.i_MtloE) m_lo <= bus.i_SrcAE;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", 32'(bus.o_BusyE), 32'(m_left > 0));
            chk("stall", 32'(bus.o_StallReqE),
                32'((m_left > 0) && (bus.i_StartE || bus.i_MfhiE || bus.i_MfloE ||
                                     bus.i_MthiE || bus.i_MtloE) && !bus.i_FlushE));
            chk("hilo", bus.o_HiLoE, bus.i_MfhiE ? m_hi : m_lo);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.i_StartE = 1'b0;
        bus.i_OpE    = 2'b00;
        bus.i_SrcAE  = '0;
        bus.i_SrcBE  = '0;
        bus.i_MfhiE  = 1'b0;
        bus.i_MfloE  = 1'b0;
        bus.i_MthiE  = 1'b0;
        bus.i_MtloE  = 1'b0;
        bus.i_FlushE = 1'b0;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.i_StartE = 1'b1;
        bus.i_OpE    = op;
        bus.i_SrcAE  = a;
        bus.i_SrcBE  = b;
        step(1);
        bus.i_StartE = 1'b0;
    endtask

    // Present MFHI/MFLO in the current cycle and compare against a literal at the negedge.
    task automatic read_chk(input string name, input bit hi, input logic [31:0] exp);
        bus.i_MfhiE = hi;
        bus.i_MfloE = !hi;
        @(negedge clk);
        chk(name, bus.o_HiLoE, exp);
        step(1);
        bus.i_MfhiE = 1'b0;
        bus.i_MfloE = 1'b0;
    endtask

    // Count consecutive negedges on which the selected output is high, bounded.
    task automatic count_high(input bit use_stall, output int n);
        bit done;
        done = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (!(use_stall ? bus.o_StallReqE : bus.o_BusyE)) done = 1'b1;
            else n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: signal still high after 100 cycles");
        end
    endtask

    initial begin
        int n;
        checks   = 0;
        errors   = 0;
        check_en = 1'b0;
        clear_in();
        rst = 1'b1;
        #2;
        check_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(bus.o_BusyE), 32'h0);
        chk("reset_lo", bus.o_HiLoE, 32'h0);
        step(1);
        rst = 1'b0;
        step(1);

        // MULTU max*max with MFLO in the following cycle.
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus.i_MfloE = 1'b1;
        count_high(1'b1, n);
        chk("t1_stall_cycles", 32'(n), 32'd33);
        chk("t1_lo", bus.o_HiLoE, 32'h0000_0001);
        step(1);
        bus.i_MfloE = 1'b0;
        read_chk("t1_hi", 1'b1, 32'hFFFF_FFFE);

        // MULT -3*7; MFHI exactly in cycle 34 must not stall.
        start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        step(33);
        bus.i_MfhiE = 1'b1;
        @(negedge clk);
        chk("t2_no_stall", 32'(bus.o_StallReqE), 32'h0);
        step(1);
        bus.i_MfhiE = 1'b0;
        read_chk("t2_hi", 1'b1, 32'hFFFF_FFFF);
        read_chk("t2_lo", 1'b0, 32'hFFFF_FFEB);

        // DIV -7/2 and DIVU 7/0.
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        step(33);
        read_chk("t3_div_lo", 1'b0, 32'hFFFF_FFFD);
        read_chk("t3_div_hi", 1'b1, 32'hFFFF_FFFF);
        start_op(2'b11, 32'd7, 32'd0);
        step(33);
        read_chk("t3_dz_lo", 1'b0, 32'hFFFF_FFFF);
        read_chk("t3_dz_hi", 1'b1, 32'd7);

        // Signed overflow divide, busy duration.
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        count_high(1'b0, n);
        chk("t4_busy_cycles", 32'(n), 32'd33);
        step(1);
        read_chk("t4_lo", 1'b0, 32'h8000_0000);
        read_chk("t4_hi", 1'b1, 32'h0);

        // MULT presented in cycle 5 of a DIV is held off until IDLE.
        start_op(2'b11, 32'd100, 32'd7);
        step(4);
        bus.i_StartE = 1'b1;
        bus.i_OpE    = 2'b00;
        bus.i_SrcAE  = 32'd6;
        bus.i_SrcBE  = 32'd7;
        count_high(1'b1, n);
        chk("t5_stall_cycles", 32'(n), 32'd29);
        step(1);
        bus.i_StartE = 1'b0;
        step(2);
        bus.i_MfloE = 1'b1;
        @(negedge clk);
        chk("t5_div_lo_kept", bus.o_HiLoE, 32'd14);
        chk("t5_stall_mid", 32'(bus.o_StallReqE), 32'h1);
        step(1);
        bus.i_MfloE = 1'b0;
        step(33);
        read_chk("t5_mul_lo", 1'b0, 32'd42);
        read_chk("t5_mul_hi", 1'b1, 32'd0);
        bus.i_FlushE = 1'b1;
        start_op(2'b00, 32'd5, 32'd5);
        bus.i_FlushE = 1'b0;
        @(negedge clk);
        chk("t5_flush_busy", 32'(bus.o_BusyE), 32'h0);
        step(1);
        read_chk("t5_flush_lo", 1'b0, 32'd42);

        // Asynchronous reset in cycle 10 of a MULT, then MTHI/MFHI.
        start_op(2'b00, 32'd3, 32'd4);
        step(9);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(bus.o_BusyE), 32'h0);
        chk("t6_rst_lo", bus.o_HiLoE, 32'h0);
        step(1);
        rst = 1'b0;
        step(1);
        bus.i_MthiE = 1'b1;
        bus.i_SrcAE = 32'h0000_1234;
        bus.i_MfhiE = 1'b1;
        @(negedge clk);
        chk("t6_same_cycle_old", bus.o_HiLoE, 32'h0);
        step(1);
        bus.i_MthiE = 1'b0;
        @(negedge clk);
        chk("t6_mfhi", bus.o_HiLoE, 32'h0000_1234);
        chk("t6_mfhi_no_stall", 32'(bus.o_StallReqE), 32'h0);
        step(1);
        clear_in();
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
